// File: rtl/ldpc_hd_syndrome_ctrl.sv
// Syndrome check and output stage for the hard-decision LDPC decoder: latches hard
// decisions, checks one H row per cycle, then retries or releases. Option: LDPC_SYN_WEIGHT_EN.
module ldpc_hd_syndrome_ctrl #(
    parameter int                N        = 8,
    parameter int                M        = 4,
    parameter logic [M*N-1:0]    H_MATRIX = 32'hF055330F,
    parameter int                MAX_ITER = 10,
    parameter int                ITER_W   = 4,
    localparam int               ROW_W    = (M > 1) ? $clog2(M) : 1,
    localparam int               WT_W     = $clog2(M + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hd_valid,
    input  logic [N-1:0]      hd_bits,
    output logic              iter_req,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_bits,
    output logic              out_success,
    output logic [ITER_W-1:0] out_iter
`ifdef LDPC_SYN_WEIGHT_EN
    ,
    output logic [WT_W-1:0]   out_weight
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HD = 2'd1,
        CHECK   = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [N-1:0]        hd_reg;
    logic [ROW_W-1:0]    row_q;
    logic                syn_or;
    logic [ITER_W-1:0]   iter_cnt;
    logic [N-1:0]        h_row;
    logic                par;
    logic                syn_next;
    logic                last_row;
    logic                start_acc;
    logic                hd_acc;
    logic                pass_dec;
    logic                limit_dec;
    logic                retry_dec;
`ifdef LDPC_SYN_WEIGHT_EN
    logic [WT_W-1:0]     wt_q;
`endif

    always_comb begin
        h_row = '0;
        for (int r = 0; r < M; r++) begin
            if (ROW_W'(r) == row_q) begin
                h_row = H_MATRIX[r*N +: N];
            end
        end
    end

    assign par       = ^(h_row & hd_reg);
    assign syn_next  = syn_or | par;
    assign last_row  = (row_q == ROW_W'(M - 1));
    assign start_acc = (state_q == IDLE) && start;
    assign hd_acc    = (state_q == WAIT_HD) && hd_valid;
    // The decision on the last row uses the syndrome including that row's parity.
    assign pass_dec  = (state_q == CHECK) && last_row && !syn_next;
    assign limit_dec = (state_q == CHECK) && last_row && syn_next
                       && (iter_cnt == ITER_W'(MAX_ITER));
    assign retry_dec = (state_q == CHECK) && last_row && syn_next
                       && (iter_cnt != ITER_W'(MAX_ITER));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = WAIT_HD;
            end
            WAIT_HD: begin
                if (hd_valid) state_d = CHECK;
            end
            CHECK: begin
                if (pass_dec || limit_dec) begin
                    state_d = OUTPUT;
                end else if (retry_dec) begin
                    state_d = WAIT_HD;
                end
            end
            OUTPUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd_reg   <= '0;
            row_q    <= '0;
            syn_or   <= 1'b0;
            iter_cnt <= '0;
        end else begin
            if (start_acc) begin
                iter_cnt <= ITER_W'(1);
            end else if (retry_dec) begin
                iter_cnt <= iter_cnt + ITER_W'(1);
            end
            if (hd_acc) begin
                hd_reg <= hd_bits;
                row_q  <= '0;
                syn_or <= 1'b0;
            end else if (state_q == CHECK) begin
                syn_or <= syn_next;
                if (!last_row) row_q <= row_q + ROW_W'(1);
            end
        end
    end

`ifdef LDPC_SYN_WEIGHT_EN
    // Weight counts unsatisfied rows; it restarts together with syn_or.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_q       <= '0;
            out_weight <= '0;
        end else begin
            if (hd_acc) begin
                wt_q <= '0;
            end else if (state_q == CHECK) begin
                wt_q <= wt_q + WT_W'(par);
            end
            if (pass_dec || limit_dec) begin
                out_weight <= wt_q + WT_W'(par);
            end
        end
    end
`endif

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_req    <= 1'b0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_bits    <= '0;
            out_success <= 1'b0;
            out_iter    <= '0;
        end else begin
            iter_req  <= retry_dec;
            busy      <= (state_d != IDLE);
            out_valid <= (state_d == OUTPUT);
            if (pass_dec || limit_dec) begin
                out_bits    <= hd_reg;
                out_success <= pass_dec;
                out_iter    <= iter_cnt;
            end
        end
    end

endmodule

// File: doc/ldpc_hd_syndrome_ctrl.md
# ldpc_hd_syndrome_ctrl

Downstream companion to the hard-decision variable-node array. It latches the N hard-decision bits produced at the end of a decoding iteration and checks them serially against the parity-check matrix, one row per cycle. It then either requests another iteration or releases the codeword, with a success flag and iteration count, over a valid/ready handshake. It is the early-termination and output stage of the hard-decision decoder.

## Interface
- N, 8, codeword length (number of variable nodes)
- M, 4, number of parity-check rows
- H_MATRIX, 32'hF055330F, flat M*N-bit matrix; bit r*N+c is H[r][c]
- MAX_ITER, 10, maximum hard-decision iterations per frame (>=1)
- ITER_W, 4, width of iteration counter (must hold MAX_ITER)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin new frame; sampled only in IDLE
- hd_valid  in  1  hd_bits valid (one-cycle strobe from VNU array); sampled only in WAIT_HD
- hd_bits  in  N  hard decisions, bit c = variable node c
- iter_req  out  1  one-cycle pulse: run another iteration
- busy  out  1  high in any state except IDLE
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_bits  out  N  latched codeword
- out_success  out  1  1 = all checks satisfied
- out_iter  out  ITER_W  iterations used (1..MAX_ITER)

## Operation
- States: IDLE, WAIT_HD, CHECK, OUTPUT.
- IDLE: start=1 -> WAIT_HD, iter_cnt=1. Otherwise stay.
- WAIT_HD: hd_valid=1 -> latch hd_bits into hd_reg, row=0, syn_or=0 -> CHECK. Otherwise stay.
- CHECK: each cycle, par = XOR-reduce(H[row] & hd_reg); syn_or |= par; row++.
  - On row = M-1, using the updated syn_or:
    - syn_or=0 -> OUTPUT with success=1.
    - Else iter_cnt=MAX_ITER -> OUTPUT with success=0.
    - Else pulse iter_req, iter_cnt++ -> WAIT_HD.
- OUTPUT: out_valid=1 and out_bits/out_success/out_iter stay stable until out_valid&&out_ready -> IDLE.
- start is ignored outside IDLE. hd_valid is ignored outside WAIT_HD, including while in CHECK.
- out_iter = iter_cnt at the decision. iter_cnt never exceeds MAX_ITER and never wraps.
- MAX_ITER=1: the first failing check goes straight to OUTPUT with success=0; iter_req never pulses.
- Reset (any state, mid-frame included): state=IDLE. iter_req, busy, out_valid, out_success=0. out_bits=0, out_iter=0, row=0, syn_or=0, hd_reg=0. The in-progress frame is discarded.

## Timing
- hd_valid accepted at edge T. CHECK occupies cycles T+1..T+M.
- Fail path: iter_req is high for cycle T+M+1, and the block is in WAIT_HD from T+M+1.
- Pass or limit path: out_valid is high from T+M+1.
- start at edge S -> busy high from S+1.
- The earliest hd_valid accepted is at S+1.
- Handshake completes at edge H -> out_valid low and busy low from H+1.
- A start at edge H+1 is accepted.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- LDPC_SYN_WEIGHT_EN defined: adds output out_weight, width $clog2(M+1).
  - out_weight = count of unsatisfied checks in the final syndrome.
  - Computed with a weight counter in CHECK that clears with syn_or.
  - Held with the other outputs during OUTPUT. Reset to 0.
- LDPC_SYN_WEIGHT_EN undefined: no port and no counter. All other behaviour is identical.

## Test plan
- Reset mid-CHECK (rst_n low for one cycle) -> all outputs 0 next cycle, state IDLE. A following start/hd_valid=8'h00 completes normally.
- start, hd_valid with hd_bits=8'h00 -> out_valid 5 cycles after hd_valid, out_success=1, out_iter=1, out_bits=8'h00; iter_req never pulses.
- start, hd_bits=8'h01 -> iter_req pulse at hd_valid+5. Then hd_bits=8'h03 -> second iter_req. Then hd_bits=8'h0F -> out_success=1, out_iter=3, out_bits=8'h0F. With LDPC_SYN_WEIGHT_EN, the first failing frame's weight is 3 (checked via an internal probe) and the final out_weight=0.
- MAX_ITER=2, hd_bits=8'h01 twice -> one iter_req, then out_success=0, out_iter=2, out_bits=8'h01. With LDPC_SYN_WEIGHT_EN, out_weight=3.
- out_ready held low 10 cycles -> out_valid and all result outputs stable. start pulses during this window are ignored. Asserting out_ready returns to IDLE next cycle.
- hd_valid pulsed during CHECK, and hd_valid asserted in IDLE -> both ignored; hd_reg and the result are unchanged.
